// File: rtl/pc_fetch_unit.sv
// Program counter owner and instruction fetcher: one fetch in flight at a time, wrong-path
// responses are drained after redirects, and a misaligned redirect target parks the unit in a fault.
module pc_fetch_unit #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            branch_confirm,
   input  logic [XLEN-1:0] branch_target,
   input  logic            jump,
   input  logic            jalr,
   input  logic [XLEN-1:0] jalr_target,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst,
   output logic [XLEN-1:0] inst_pc,
   output logic            misalign_fault
);

   typedef enum logic [2:0] {StReq, StWait, StDrain, StHold, StFault} state_e;

   state_e          state_q;
   logic [XLEN-1:0] pc_q;
   logic            req_valid_q;
   logic [31:0]     inst_q;
   logic [XLEN-1:0] inst_pc_q;
   logic            inst_valid_q;
   logic            fault_q;

   logic            redirect;
   logic [XLEN-1:0] target;
   logic            misaligned;
   logic            req_fire;

   assign redirect   = branch_confirm | jump;
   assign target     = jalr ? {jalr_target[XLEN-1:1], 1'b0} : branch_target;
   assign misaligned = (target[1:0] != 2'b00);
   assign req_fire   = req_valid_q & imem_req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StReq;
         pc_q         <= RESET_PC;
         req_valid_q  <= 1'b0;
         inst_q       <= '0;
         inst_pc_q    <= '0;
         inst_valid_q <= 1'b0;
         fault_q      <= 1'b0;
      end else if (state_q != StFault && redirect && misaligned) begin
         // A bad target is terminal; pc keeps the last good value.
         state_q      <= StFault;
         fault_q      <= 1'b1;
         req_valid_q  <= 1'b0;
         inst_valid_q <= 1'b0;
      end else begin
         case (state_q)
            StReq: begin
               if (redirect) begin
                  pc_q <= target;
                  if (req_fire) begin
                     state_q     <= StDrain;
                     req_valid_q <= 1'b0;
                  end else begin
                     req_valid_q <= 1'b1;
                  end
               end else if (req_fire) begin
                  state_q     <= StWait;
                  req_valid_q <= 1'b0;
               end else begin
                  req_valid_q <= 1'b1;
               end
            end
            StWait: begin
               if (redirect) begin
                  // A response landing with the redirect is already gone, so skip the drain.
                  pc_q        <= target;
                  state_q     <= imem_rsp_valid ? StReq : StDrain;
                  req_valid_q <= imem_rsp_valid;
               end else if (imem_rsp_valid) begin
                  inst_q       <= imem_rsp_data;
                  inst_pc_q    <= pc_q;
                  inst_valid_q <= 1'b1;
                  state_q      <= StHold;
               end
            end
            StDrain: begin
               if (redirect) begin
                  pc_q <= target;
               end
               if (imem_rsp_valid) begin
                  state_q     <= StReq;
                  req_valid_q <= 1'b1;
               end
            end
            StHold: begin
               if (redirect) begin
                  pc_q         <= target;
                  inst_valid_q <= 1'b0;
                  state_q      <= StReq;
                  req_valid_q  <= 1'b1;
               end else if (inst_ready) begin
                  pc_q         <= pc_q + XLEN'(4);
                  inst_valid_q <= 1'b0;
                  state_q      <= StReq;
                  req_valid_q  <= 1'b1;
               end
            end
            StFault: begin
            end
            default: begin
               state_q     <= StReq;
               req_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req_valid = req_valid_q;
   assign imem_addr      = pc_q;
   assign inst_valid     = inst_valid_q;
   assign inst           = inst_q;
   assign inst_pc        = inst_pc_q;
   assign misalign_fault = fault_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit: a transaction-level fetch model feeds a scoreboard queue that
// an independent monitor drains whenever a new instruction is presented downstream.
module tb_pc_fetch_unit;

   localparam int unsigned XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            branch_confirm = 1'b0;
   logic [XLEN-1:0] branch_target = '0;
   logic            jump = 1'b0;
   logic            jalr = 1'b0;
   logic [XLEN-1:0] jalr_target = '0;
   logic            imem_req_valid;
   logic            imem_req_ready = 1'b0;
   logic [XLEN-1:0] imem_addr;
   logic            imem_rsp_valid = 1'b0;
   logic [31:0]     imem_rsp_data = '0;
   logic            inst_valid;
   logic            inst_ready = 1'b0;
   logic [31:0]     inst;
   logic [XLEN-1:0] inst_pc;
   logic            misalign_fault;

   always #5 clk = ~clk;

   pc_fetch_unit #(
      .XLEN     (XLEN),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .branch_confirm (branch_confirm),
      .branch_target  (branch_target),
      .jump           (jump),
      .jalr           (jalr),
      .jalr_target    (jalr_target),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .misalign_fault (misalign_fault)
   );

   int checks = 0;
   int errors = 0;
   int delivered = 0;

   // Expected deliveries, {pc, instruction}.
   logic [63:0] sb_q[$];

   // Reference model: architectural pc plus a few transaction flags.
   logic [31:0] m_pc;
   bit          m_fault, m_req_en, m_pending, m_wrong, m_hold;

   // Memory model.
   bit          mem_busy;
   int          mem_cnt;
   logic [31:0] mem_data;

   int p_redir, p_ready, p_iready, p_spur, lat_max;
   bit allow_mis, force13;

   bit          mon_en = 1'b0;
   bit          prev_v = 1'b0;
   logic [31:0] last_inst, last_pc;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [31:0] rand_addr();
      if ($urandom_range(9) == 0) return 32'hFFFF_FFFC;
      return $urandom & 32'h0000_FFFC;
   endfunction

   task automatic model_reset();
      m_pc = 32'h0; m_fault = 0; m_req_en = 0; m_pending = 0; m_wrong = 0; m_hold = 0;
      sb_q.delete();
      prev_v = 0;
   endtask

   task automatic do_reset(int cycles);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      branch_confirm = 0; jump = 0; jalr = 0; imem_req_ready = 0; imem_rsp_valid = 0;
      inst_ready = 0;
      model_reset();
      #2;
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_inst", inst, 0);
      chk("rst_inst_pc", inst_pc, 0);
      chk("rst_fault", misalign_fault, 0);
      repeat (cycles) @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic step();
      logic [31:0] tgt;
      bit r, acc, was_hold;
      @(negedge clk);
      chk("req_valid", imem_req_valid, m_req_en);
      chk("imem_addr", imem_addr, m_pc);
      chk("inst_valid", inst_valid, m_hold);
      chk("misalign_fault", misalign_fault, m_fault);

      branch_confirm = 0;
      jump = 0;
      jalr = 1'($urandom_range(1));
      branch_target = rand_addr();
      jalr_target = rand_addr() | 32'($urandom_range(1));
      if ($urandom_range(99) < p_redir) begin
         if ($urandom_range(1) == 1) begin
            branch_confirm = 1;
            jalr = 0;
         end else begin
            jump = 1;
         end
         if (allow_mis && $urandom_range(3) == 0) begin
            branch_target[1] = 1'b1;
            jalr_target[1] = 1'b1;
         end
      end
      imem_req_ready = !mem_busy && ($urandom_range(99) < p_ready);
      if (mem_busy) begin
         if (mem_cnt == 0) begin
            imem_rsp_valid = 1;
            imem_rsp_data = mem_data;
            mem_busy = 0;
         end else begin
            mem_cnt--;
            imem_rsp_valid = 0;
            imem_rsp_data = $urandom;
         end
      end else begin
         imem_rsp_valid = ($urandom_range(99) < p_spur);
         imem_rsp_data = $urandom;
      end
      inst_ready = ($urandom_range(99) < p_iready);

      @(posedge clk);
      r = branch_confirm | jump;
      tgt = jalr ? (jalr_target & 32'hFFFF_FFFE) : branch_target;
      acc = m_req_en && imem_req_ready;
      if (!m_fault) begin
         if (r && tgt[1:0] != 2'b00) begin
            m_fault = 1; m_req_en = 0; m_hold = 0; m_pending = 0;
         end else begin
            was_hold = m_hold;
            if (m_pending && imem_rsp_valid) begin
               if (!m_wrong && !r) begin
                  sb_q.push_back({m_pc, imem_rsp_data});
                  m_hold = 1;
               end
               m_pending = 0;
            end else if (m_pending && r) begin
               m_wrong = 1;
            end
            if (acc) begin
               m_pending = 1;
               m_wrong = r;
            end
            if (r) begin
               m_pc = tgt;
               m_hold = 0;
            end else if (was_hold && inst_ready) begin
               m_pc = m_pc + 32'd4;
               m_hold = 0;
            end
            m_req_en = !m_pending && !m_hold;
         end
      end
      if (acc) begin
         mem_busy = 1;
         mem_cnt = $urandom_range(lat_max);
         mem_data = force13 ? 32'h0000_0013 : $urandom;
         force13 = 0;
      end
   endtask

   // Monitor: pops one expectation per new presentation, checks stability while held.
   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         if (inst_valid && !prev_v) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_inst: got pc %h inst %h expected none at %0t",
                        inst_pc, inst, $time);
            end else begin
               logic [63:0] e;
               e = sb_q.pop_front();
               if ({inst_pc, inst} !== e) begin
                  errors++;
                  $display("FAIL inst_sb: got pc %h inst %h expected pc %h inst %h at %0t",
                           inst_pc, inst, e[63:32], e[31:0], $time);
               end else begin
                  delivered++;
               end
            end
         end else if (inst_valid && prev_v) begin
            checks++;
            if (inst !== last_inst || inst_pc !== last_pc) begin
               errors++;
               $display("FAIL inst_stable: got pc %h inst %h expected pc %h inst %h at %0t",
                        inst_pc, inst, last_pc, last_inst, $time);
            end
         end
         prev_v = inst_valid;
         last_inst = inst;
         last_pc = inst_pc;
      end
   end

   initial begin
      mem_busy = 0; mem_cnt = 0; mem_data = '0;
      allow_mis = 0; force13 = 1;
      p_redir = 0; p_ready = 100; p_iready = 100; p_spur = 0; lat_max = 0;
      model_reset();
      do_reset(2);
      mon_en = 1;

      // Straight-line fetch: first word 0x13 at pc 0, then pc 4.
      repeat (12) step();
      // Downstream stall.
      p_iready = 0;
      repeat (10) step();
      p_iready = 100;
      repeat (6) step();

      for (int k = 0; k < 6; k++) begin
         p_redir  = 5 + 5 * k;
         p_ready  = 40 + 10 * k;
         p_iready = 30 + 10 * k;
         p_spur   = 10;
         lat_max  = k % 3;
         repeat (500) step();
         do_reset(1 + k % 2);
      end

      // Misaligned redirects until trapped, then redirects must be ignored.
      p_redir = 30;
      allow_mis = 1;
      for (int i = 0; i < 400 && !m_fault; i++) step();
      p_redir = 60;
      repeat (20) step();
      do_reset(2);
      allow_mis = 0;
      p_redir = 10;
      repeat (60) step();

      @(negedge clk);
      @(negedge clk);
      #1;
      chk("sb_drained", 64'(sb_q.size()), 0);
      chk("progress", 64'(delivered > 200), 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Owns the program counter and fetches instructions from instruction memory over a valid/ready request plus valid response interface. It presents fetched instructions downstream with a valid/ready handshake. It consumes BranchConfirm from the branch control unit, and JAL/JALR indications from decode, to redirect the PC. Wrong-path responses are discarded, and misaligned targets are trapped.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
branch_confirm  input  1  taken conditional branch (BranchConfirm)
branch_target  input  XLEN  PC+imm target for branches and JAL
jump  input  1  JAL or JALR taken unconditionally
jalr  input  1  selects jalr_target; meaningful only with jump
jalr_target  input  XLEN  rs1+imm target
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_addr  output  XLEN  fetch address
imem_rsp_valid  input  1  response data valid
imem_rsp_data  input  32  fetched instruction word
inst_valid  output  1  instruction available downstream
inst_ready  input  1  downstream consumes instruction
inst  output  32  instruction word
inst_pc  output  XLEN  PC of inst
misalign_fault  output  1  sticky misaligned-target flag

Behaviour:
- Reset is asynchronous and active-low on rst_n; clk is the single clock. While rst_n=0: pc=RESET_PC, state=S_REQ, imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, misalign_fault=0.
- imem_req_valid is asserted only in S_REQ, from the first clk edge after reset release. imem_addr always equals pc.
- redirect = branch_confirm | jump. target = jalr ? {jalr_target[XLEN-1:1],1'b0} : branch_target. Redirect beats every other event in the same cycle.
- The misaligned check uses target[1:0] != 0, evaluated after the JALR bit-0 clear. On a redirect with a misaligned target: misalign_fault<=1, state<=S_FAULT, pc is unchanged.
- S_REQ, no redirect: if imem_req_ready=1, go to S_WAIT; otherwise hold, keeping imem_addr stable.
- S_REQ, redirect:
  - pc<=target.
  - If the request is accepted in the same cycle, go to S_DRAIN (the in-flight fetch is wrong-path).
  - Otherwise stay in S_REQ with the new address.
- S_WAIT:
  - On imem_rsp_valid: inst<=imem_rsp_data, inst_pc<=pc, inst_valid<=1, go to S_HOLD.
  - On redirect: pc<=target, go to S_DRAIN.
  - If redirect and the response arrive together, the response is dropped, pc<=target, and the state goes directly to S_REQ (the response already arrived, so there is nothing to drain).
- S_DRAIN: imem_req_valid=0. Wait for imem_rsp_valid, discard the data, go to S_REQ. A further redirect while in S_DRAIN updates pc only.
- S_HOLD:
  - inst, inst_pc and inst_valid are stable while inst_ready=0.
  - On inst_ready=1 with no redirect: inst_valid<=0, pc<=pc+4 (modulo 2^XLEN, wraps 32'hFFFF_FFFC to 0), go to S_REQ.
  - On redirect: inst_valid<=0, pc<=target, go to S_REQ (the held instruction is dropped even if inst_ready=1).
- S_FAULT: terminal. imem_req_valid=0 and inst_valid=0. Redirects and responses are ignored. Only rst_n exits.
- Memory contract: at most one request outstanding. The response arrives no earlier than the cycle after acceptance. Responses while not in S_WAIT or S_DRAIN are ignored.
- Throughput: one instruction per 3 cycles minimum (REQ, WAIT, HOLD). No prefetch.
- Reset asserted mid-operation aborts everything immediately. Any response still in flight after reset release is ignored, because the FSM is in S_REQ.

Test Plan:
- Reset release, imem_req_ready=1, response 1 cycle later with 32'h00000013: imem_addr=0, inst_valid=1, inst=32'h00000013, inst_pc=0. After inst_ready, next imem_addr=4.
- Hold inst_ready=0 for 5 cycles: inst and inst_pc stay unchanged, with no new request. Then inst_ready=1: next fetch at pc+4.
- branch_confirm=1 with branch_target=32'h40 while in S_WAIT: the in-flight response (32'hDEADBEEF) is never seen as inst_valid. The next request uses imem_addr=32'h40.
- jump=1, jalr=1, jalr_target=32'h101: redirect goes to 32'h100, with no fault.
- jump=1, jalr=0, branch_target=32'h102: misalign_fault=1, with no further requests. Redirects are ignored until rst_n pulses low.
- pc=32'hFFFF_FFFC and instruction consumed: next imem_addr=0. Redirect and inst_ready both high in S_HOLD: redirect wins.
